ctrl_pipe: RTL and testbench

- Consumer end of the main decoder `Ctr` interface in the pipelined MIPS core.
- Takes the ID-stage control word (`regDst`, `aluSrc`, `memToReg`, `regWrite`, `memRead`, `memWrite`, `branch`, `aluOp`, `jump`) plus register fields and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards, inserts bubbles, and applies branch/jump flushes.
- Drives stall/flush controls back to the PC and the IF/ID register.

---
 rtl/mips_pkg.sv | 87 ++++++++
 rtl/hazard_unit.sv | 29 ++
 rtl/ctrl_pipe.sv | 140 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: opcodes, ALU op codes and the
// decoder control word layout used by Ctr and the pipeline control registers.
package mips_pkg;

   localparam int REG_W   = 5;
   localparam int ALUOP_W = 2;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

   // Bit ordering matches the Ctr output bundle.
   typedef struct packed {
      logic               regDst;
      logic               aluSrc;
      logic               memToReg;
      logic               regWrite;
      logic               memRead;
      logic               memWrite;
      logic               branch;
      logic               jump;
      logic [ALUOP_W-1:0] aluOp;
   } ctrl_word_t;

   typedef struct packed {
      logic               regDst;
      logic               aluSrc;
      logic               memToReg;
      logic               regWrite;
      logic               memRead;
      logic               memWrite;
      logic               branch;
      logic [ALUOP_W-1:0] aluOp;
   } ex_ctrl_t;

   typedef struct packed {
      logic memRead;
      logic memWrite;
      logic branch;
      logic memToReg;
      logic regWrite;
   } mem_ctrl_t;

   typedef struct packed {
      logic memToReg;
      logic regWrite;
   } wb_ctrl_t;

   // Reference decode of the main decoder, kept beside the layout it fills.
   function automatic ctrl_word_t ctr_decode(input logic [5:0] op);
      ctrl_word_t cw;
      cw = '0;
      case (op)
         OP_RTYPE: begin
            cw.regDst   = 1'b1;
            cw.regWrite = 1'b1;
            cw.aluOp    = ALUOP_FUNCT;
         end
         OP_LW: begin
            cw.aluSrc   = 1'b1;
            cw.memToReg = 1'b1;
            cw.regWrite = 1'b1;
            cw.memRead  = 1'b1;
            cw.aluOp    = ALUOP_ADD;
         end
         OP_SW: begin
            cw.aluSrc   = 1'b1;
            cw.memWrite = 1'b1;
            cw.aluOp    = ALUOP_ADD;
         end
         OP_BEQ: begin
            cw.branch = 1'b1;
            cw.aluOp  = ALUOP_SUB;
         end
         OP_J:    cw.jump = 1'b1;
         default: cw = '0;
      endcase
      return cw;
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use detection and stall/flush priority for the pipeline control path.
// A taken branch discards everything younger, so it wins over a load-use stall.
module hazard_unit #(
   parameter int REG_W = 5
) (
   input  logic             exMemRead_i,
   input  logic [REG_W-1:0] exRt_i,
   input  logic [REG_W-1:0] idRs_i,
   input  logic [REG_W-1:0] idRt_i,
   input  logic             jump_i,
   input  logic             branchTaken_i,
   output logic             idExBubble_o,
   output logic             pcStall_o,
   output logic             ifIdStall_o,
   output logic             ifIdFlush_o,
   output logic             idExFlush_o
);

   logic load_use;

   assign load_use     = exMemRead_i & ((exRt_i == idRs_i) | (exRt_i == idRt_i));
   assign pcStall_o    = load_use & ~branchTaken_i;
   assign ifIdStall_o  = load_use & ~branchTaken_i;
   // A jump held in ID by a stall is re-presented next cycle, so no flush yet.
   assign ifIdFlush_o  = branchTaken_i | (jump_i & ~load_use);
   assign idExFlush_o  = branchTaken_i;
   assign idExBubble_o = load_use | branchTaken_i;

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers of the pipelined MIPS core,
// with load-use bubbles, branch/jump flushes and $0 write suppression.
module ctrl_pipe #(
   parameter int REG_W   = mips_pkg::REG_W,
   parameter int ALUOP_W = mips_pkg::ALUOP_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               regDst,
   input  logic               aluSrc,
   input  logic               memToReg,
   input  logic               regWrite,
   input  logic               memRead,
   input  logic               memWrite,
   input  logic               branch,
   input  logic               jump,
   input  logic [ALUOP_W-1:0] aluOp,
   input  logic [REG_W-1:0]   idRs,
   input  logic [REG_W-1:0]   idRt,
   input  logic [REG_W-1:0]   idRd,
   input  logic               branchTaken,
   output logic               exRegDst,
   output logic               exAluSrc,
   output logic               exMemRead,
   output logic               exMemWrite,
   output logic               exBranch,
   output logic               exMemToReg,
   output logic               exRegWrite,
   output logic [ALUOP_W-1:0] exAluOp,
   output logic [REG_W-1:0]   exRt,
   output logic               memMemRead,
   output logic               memMemWrite,
   output logic               memBranch,
   output logic               memMemToReg,
   output logic               memRegWrite,
   output logic [REG_W-1:0]   memWriteReg,
   output logic               wbMemToReg,
   output logic               wbRegWrite,
   output logic [REG_W-1:0]   wbWriteReg,
   output logic               pcStall,
   output logic               ifIdStall,
   output logic               ifIdFlush,
   output logic               idExFlush
);

   mips_pkg::ctrl_word_t id_cw;
   mips_pkg::ex_ctrl_t   ex_ctrl_q, ex_ctrl_d;
   mips_pkg::mem_ctrl_t  mem_ctrl_q, mem_ctrl_d;
   mips_pkg::wb_ctrl_t   wb_ctrl_q, wb_ctrl_d;
   logic [REG_W-1:0]     ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
   logic [REG_W-1:0]     mem_wr_q, mem_wr_d, wb_wr_q, wb_wr_d;
   logic [REG_W-1:0]     ex_dest;
   logic                 id_ex_bubble;

   assign id_cw = '{regDst: regDst, aluSrc: aluSrc, memToReg: memToReg,
                    regWrite: regWrite, memRead: memRead, memWrite: memWrite,
                    branch: branch, jump: jump, aluOp: aluOp};

   hazard_unit #(.REG_W(REG_W)) u_hazard (
      .exMemRead_i   (ex_ctrl_q.memRead),
      .exRt_i        (ex_rt_q),
      .idRs_i        (idRs),
      .idRt_i        (idRt),
      .jump_i        (id_cw.jump),
      .branchTaken_i (branchTaken),
      .idExBubble_o  (id_ex_bubble),
      .pcStall_o     (pcStall),
      .ifIdStall_o   (ifIdStall),
      .ifIdFlush_o   (ifIdFlush),
      .idExFlush_o   (idExFlush)
   );

   always_comb begin
      ex_ctrl_d  = '0;
      ex_rt_d    = '0;
      ex_rd_d    = '0;
      mem_ctrl_d = '0;
      mem_wr_d   = '0;
      ex_dest    = ex_ctrl_q.regDst ? ex_rd_q : ex_rt_q;
      if (!id_ex_bubble) begin
         ex_ctrl_d = '{regDst: id_cw.regDst, aluSrc: id_cw.aluSrc,
                       memToReg: id_cw.memToReg, regWrite: id_cw.regWrite,
                       memRead: id_cw.memRead, memWrite: id_cw.memWrite,
                       branch: id_cw.branch, aluOp: id_cw.aluOp};
         ex_rt_d   = idRt;
         ex_rd_d   = idRd;
      end
      // The instruction in EX is younger than a taken branch in MEM: squash it.
      if (!idExFlush) begin
         mem_ctrl_d.memRead  = ex_ctrl_q.memRead;
         mem_ctrl_d.memWrite = ex_ctrl_q.memWrite;
         mem_ctrl_d.branch   = ex_ctrl_q.branch;
         mem_ctrl_d.memToReg = ex_ctrl_q.memToReg;
         mem_ctrl_d.regWrite = ex_ctrl_q.regWrite & (ex_dest != '0);
         mem_wr_d            = ex_dest;
      end
      wb_ctrl_d = '{memToReg: mem_ctrl_q.memToReg, regWrite: mem_ctrl_q.regWrite};
      wb_wr_d   = mem_wr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl_q  <= '0;
         ex_rt_q    <= '0;
         ex_rd_q    <= '0;
         mem_ctrl_q <= '0;
         mem_wr_q   <= '0;
         wb_ctrl_q  <= '0;
         wb_wr_q    <= '0;
      end else begin
         ex_ctrl_q  <= ex_ctrl_d;
         ex_rt_q    <= ex_rt_d;
         ex_rd_q    <= ex_rd_d;
         mem_ctrl_q <= mem_ctrl_d;
         mem_wr_q   <= mem_wr_d;
         wb_ctrl_q  <= wb_ctrl_d;
         wb_wr_q    <= wb_wr_d;
      end
   end

   assign exRegDst    = ex_ctrl_q.regDst;
   assign exAluSrc    = ex_ctrl_q.aluSrc;
   assign exMemRead   = ex_ctrl_q.memRead;
   assign exMemWrite  = ex_ctrl_q.memWrite;
   assign exBranch    = ex_ctrl_q.branch;
   assign exMemToReg  = ex_ctrl_q.memToReg;
   assign exRegWrite  = ex_ctrl_q.regWrite;
   assign exAluOp     = ex_ctrl_q.aluOp;
   assign exRt        = ex_rt_q;
   assign memMemRead  = mem_ctrl_q.memRead;
   assign memMemWrite = mem_ctrl_q.memWrite;
   assign memBranch   = mem_ctrl_q.branch;
   assign memMemToReg = mem_ctrl_q.memToReg;
   assign memRegWrite = mem_ctrl_q.regWrite;
   assign memWriteReg = mem_wr_q;
   assign wbMemToReg  = wb_ctrl_q.memToReg;
   assign wbRegWrite  = wb_ctrl_q.regWrite;
   assign wbWriteReg  = wb_wr_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: R-type flow, load-use stall, branch/jump
// flushes, $0 write suppression and asynchronous reset.
module tb_ctrl_pipe;

   localparam int REG_W   = 5;
   localparam int ALUOP_W = 2;

   // {regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, jump}
   localparam logic [7:0] F_NOP   = 8'b0000_0000;
   localparam logic [7:0] F_RTYPE = 8'b1001_0000;
   localparam logic [7:0] F_LW    = 8'b0111_1000;
   localparam logic [7:0] F_BEQ   = 8'b0000_0010;
   localparam logic [7:0] F_J     = 8'b0000_0001;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               regDst, aluSrc, memToReg, regWrite;
   logic               memRead, memWrite, branch, jump;
   logic [ALUOP_W-1:0] aluOp;
   logic [REG_W-1:0]   idRs, idRt, idRd;
   logic               branchTaken;
   logic               exRegDst, exAluSrc, exMemRead, exMemWrite;
   logic               exBranch, exMemToReg, exRegWrite;
   logic [ALUOP_W-1:0] exAluOp;
   logic [REG_W-1:0]   exRt;
   logic               memMemRead, memMemWrite, memBranch, memMemToReg, memRegWrite;
   logic [REG_W-1:0]   memWriteReg;
   logic               wbMemToReg, wbRegWrite;
   logic [REG_W-1:0]   wbWriteReg;
   logic               pcStall, ifIdStall, ifIdFlush, idExFlush;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   ctrl_pipe #(.REG_W(REG_W), .ALUOP_W(ALUOP_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .regDst(regDst), .aluSrc(aluSrc), .memToReg(memToReg), .regWrite(regWrite),
      .memRead(memRead), .memWrite(memWrite), .branch(branch), .jump(jump),
      .aluOp(aluOp), .idRs(idRs), .idRt(idRt), .idRd(idRd),
      .branchTaken(branchTaken),
      .exRegDst(exRegDst), .exAluSrc(exAluSrc), .exMemRead(exMemRead),
      .exMemWrite(exMemWrite), .exBranch(exBranch), .exMemToReg(exMemToReg),
      .exRegWrite(exRegWrite), .exAluOp(exAluOp), .exRt(exRt),
      .memMemRead(memMemRead), .memMemWrite(memMemWrite), .memBranch(memBranch),
      .memMemToReg(memMemToReg), .memRegWrite(memRegWrite), .memWriteReg(memWriteReg),
      .wbMemToReg(wbMemToReg), .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg),
      .pcStall(pcStall), .ifIdStall(ifIdStall), .ifIdFlush(ifIdFlush),
      .idExFlush(idExFlush)
   );

   // Clock
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Driver tasks
   task automatic set_id(input logic [7:0] flags, input logic [1:0] op,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
      {regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, jump} = flags;
      aluOp = op;
      idRs  = rs;
      idRt  = rt;
      idRd  = rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held with nonzero inputs
      rst_n       = 1'b0;
      branchTaken = 1'b0;
      set_id(F_LW, 2'b00, 5'd3, 5'd3, 5'd7);
      step();
      step();
      check("rst_exRegWrite",  exRegWrite,  0);
      check("rst_exMemRead",   exMemRead,   0);
      check("rst_exRt",        exRt,        0);
      check("rst_memRegWrite", memRegWrite, 0);
      check("rst_wbRegWrite",  wbRegWrite,  0);
      check("rst_pcStall",     pcStall,     0);
      @(negedge clk);
      rst_n = 1'b1;

      // R-type add $3, no hazards
      set_id(F_RTYPE, 2'b10, 5'd1, 5'd4, 5'd3);
      #1;
      check("r_pcStall", pcStall, 0);
      step();
      check("r_exAluOp",    exAluOp,    2'b10);
      check("r_exRegDst",   exRegDst,   1);
      check("r_exRegWrite", exRegWrite, 1);
      set_id(F_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
      step();
      check("r_memWriteReg", memWriteReg, 3);
      check("r_memRegWrite", memRegWrite, 1);
      step();
      check("r_wbRegWrite", wbRegWrite, 1);
      check("r_wbWriteReg", wbWriteReg, 3);

      // lw $2 followed by dependent add
      set_id(F_LW, 2'b00, 5'd1, 5'd2, 5'd0);
      step();
      check("lu_exMemRead", exMemRead, 1);
      set_id(F_RTYPE, 2'b10, 5'd2, 5'd5, 5'd6);
      #1;
      check("lu_pcStall",   pcStall,   1);
      check("lu_ifIdStall", ifIdStall, 1);
      check("lu_ifIdFlush", ifIdFlush, 0);
      check("lu_idExFlush", idExFlush, 0);
      step();
      check("lu_bub_exRegWrite", exRegWrite, 0);
      check("lu_bub_exRegDst",   exRegDst,   0);
      check("lu_bub_exAluOp",    exAluOp,    0);
      check("lu_bub_exMemRead",  exMemRead,  0);
      check("lu_memMemRead",     memMemRead, 1);
      check("lu_memWriteReg",    memWriteReg, 2);
      check("lu_memRegWrite",    memRegWrite, 1);
      check("lu_pcStall_end",    pcStall,    0);
      step();
      check("lu_add_exRegDst", exRegDst, 1);
      check("lu_add_exAluOp",  exAluOp,  2'b10);
      check("lu_add_exRt",     exRt,     5);
      check("lu_wbWriteReg",   wbWriteReg, 2);
      check("lu_wbMemToReg",   wbMemToReg, 1);
      check("lu_wbRegWrite",   wbRegWrite, 1);

      // Taken beq in MEM, lw in EX, dependent instruction in ID
      set_id(F_BEQ, 2'b01, 5'd1, 5'd1, 5'd0);
      step();
      set_id(F_LW, 2'b00, 5'd3, 5'd8, 5'd0);
      step();
      check("br_memBranch", memBranch, 1);
      check("br_exMemRead", exMemRead, 1);
      set_id(F_RTYPE, 2'b10, 5'd8, 5'd1, 5'd9);
      branchTaken = 1'b1;
      #1;
      check("br_ifIdFlush", ifIdFlush, 1);
      check("br_idExFlush", idExFlush, 1);
      check("br_pcStall",   pcStall,   0);
      check("br_ifIdStall", ifIdStall, 0);
      step();
      branchTaken = 1'b0;
      check("br_exMemRead",   exMemRead,   0);
      check("br_exRegWrite",  exRegWrite,  0);
      check("br_exAluOp",     exAluOp,     0);
      check("br_memMemRead",  memMemRead,  0);
      check("br_memMemToReg", memMemToReg, 0);
      check("br_memRegWrite", memRegWrite, 0);
      check("br_memBranch0",  memBranch,   0);
      check("br_wbRegWrite",  wbRegWrite,  0);
      set_id(F_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
      step();

      // Jump without hazard
      set_id(F_J, 2'b00, 5'd0, 5'd0, 5'd0);
      #1;
      check("j_ifIdFlush", ifIdFlush, 1);
      check("j_idExFlush", idExFlush, 0);
      check("j_pcStall",   pcStall,   0);
      step();
      check("j_exRegWrite", exRegWrite, 0);
      set_id(F_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
      #1;
      check("j_ifIdFlush_end", ifIdFlush, 0);

      // Jump while a load-use stall is active
      set_id(F_LW, 2'b00, 5'd1, 5'd10, 5'd0);
      step();
      set_id(F_J, 2'b00, 5'd10, 5'd0, 5'd0);
      #1;
      check("jlu_pcStall",   pcStall,   1);
      check("jlu_ifIdFlush", ifIdFlush, 0);
      step();
      check("jlu_ifIdFlush_retry", ifIdFlush, 1);
      check("jlu_pcStall_end",     pcStall,   0);
      set_id(F_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
      step();

      // Write to $11 then write to $0
      set_id(F_RTYPE, 2'b10, 5'd1, 5'd2, 5'd11);
      step();
      set_id(F_RTYPE, 2'b10, 5'd1, 5'd2, 5'd0);
      step();
      check("z_memRegWrite_r11", memRegWrite, 1);
      check("z_memWriteReg_r11", memWriteReg, 11);
      set_id(F_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
      step();
      check("z_memRegWrite_r0", memRegWrite, 0);
      check("z_wbRegWrite_r11", wbRegWrite,  1);
      check("z_wbWriteReg_r11", wbWriteReg,  11);
      step();
      check("z_wbRegWrite_r0", wbRegWrite, 0);

      // Asynchronous reset mid-stream
      set_id(F_RTYPE, 2'b10, 5'd1, 5'd2, 5'd13);
      step();
      set_id(F_LW, 2'b00, 5'd1, 5'd12, 5'd0);
      step();
      set_id(F_RTYPE, 2'b10, 5'd12, 5'd4, 5'd14);
      #1;
      check("ar_pcStall_pre", pcStall, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_exMemRead",   exMemRead,   0);
      check("ar_exRt",        exRt,        0);
      check("ar_exAluOp",     exAluOp,     0);
      check("ar_memRegWrite", memRegWrite, 0);
      check("ar_memWriteReg", memWriteReg, 0);
      check("ar_pcStall",     pcStall,     0);
      step();
      check("ar_wbRegWrite", wbRegWrite, 0);
      check("ar_wbWriteReg", wbWriteReg, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Final report
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
